// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing logic.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        MEM_WAIT = 2'd3
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Operand-forward select for one E-stage source register.
// x0 is never forwarded; the younger M result wins over W.
module forward_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_rs,
    input  logic [ADDR_W-1:0] i_rd_m,
    input  logic [ADDR_W-1:0] i_rd_w,
    input  logic              i_reg_write_m,
    input  logic              i_reg_write_w,
    output fwd_sel_t          o_sel
);

    // Pick the most recent in-flight producer of i_rs.
    always_comb begin
        o_sel = FWD_RF;
        if (i_rs != '0) begin
            if (i_reg_write_m && (i_rd_m == i_rs)) begin
                o_sel = FWD_M;
            end else if (i_reg_write_w && (i_rd_w == i_rs)) begin
                o_sel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard/sequencing controller for the 5-stage pipeline:
// stalls, flushes, operand forwarding and a saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned REG_ADDR_W       = pipeline_pkg::REG_ADDR_W,
    parameter int unsigned BOOT_BUBBLES     = 1,
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  load_e,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    input  logic                  pc_src_e,
    input  logic                  mem_req_m,
    input  logic                  mem_ready_m,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            fwd_a_e,
    output logic [1:0]            fwd_b_e,
    output logic [CNT_W-1:0]      stall_cycles
);

    import pipeline_pkg::*;

    localparam int unsigned BB_MAX = (BOOT_BUBBLES > REDIRECT_BUBBLES) ? BOOT_BUBBLES : REDIRECT_BUBBLES;
    localparam int unsigned BB_W   = ($clog2(BB_MAX + 1) < 1) ? 1 : $clog2(BB_MAX + 1);

    localparam logic [BB_W-1:0]  BOOT_CNT  = BB_W'(BOOT_BUBBLES);
    localparam logic [BB_W-1:0]  REDIR_CNT = BB_W'(REDIRECT_BUBBLES);
    localparam logic [BB_W-1:0]  CNT_ONE   = BB_W'(1);
    localparam logic [CNT_W-1:0] PERF_ONE  = CNT_W'(1);
    localparam hz_state_t        RST_STATE = (BOOT_BUBBLES == 0) ? RUN : BOOT;

    hz_state_t        r_state;
    hz_state_t        r_saved;
    logic [BB_W-1:0]  r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    hz_state_t        w_state_nxt;
    hz_state_t        w_saved_nxt;
    hz_state_t        w_eff_state;
    logic [BB_W-1:0]  w_cnt_nxt;
    logic             w_mem_stall;
    logic             w_load_use;
    fwd_sel_t         w_fwd_a;
    fwd_sel_t         w_fwd_b;

    assign w_mem_stall = mem_req_m && !mem_ready_m;
    assign w_load_use  = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    forward_unit #(.ADDR_W(REG_ADDR_W)) u_fwd_a (
        .i_rs          (rs1_e),
        .i_rd_m        (rd_m),
        .i_rd_w        (rd_w),
        .i_reg_write_m (reg_write_m),
        .i_reg_write_w (reg_write_w),
        .o_sel         (w_fwd_a)
    );

    forward_unit #(.ADDR_W(REG_ADDR_W)) u_fwd_b (
        .i_rs          (rs2_e),
        .i_rd_m        (rd_m),
        .i_rd_w        (rd_w),
        .i_reg_write_m (reg_write_m),
        .i_reg_write_w (reg_write_w),
        .o_sel         (w_fwd_b)
    );

    assign fwd_a_e      = w_fwd_a;
    assign fwd_b_e      = w_fwd_b;
    assign stall_cycles = r_stall_cycles;

    // A released memory wait behaves, in that same cycle, exactly like the state it interrupted,
    // so a redirect or load-use held in E is acted on as the pipeline starts moving again.
    always_comb begin
        w_eff_state = r_state;
        if ((r_state == MEM_WAIT) && !w_mem_stall) begin
            w_eff_state = r_saved;
        end
    end

    // Next-state and stall/flush decode; outputs forced to the reset pattern while rst_n is low.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        w_state_nxt = w_eff_state;
        w_saved_nxt = r_saved;
        w_cnt_nxt   = r_cnt;

        unique case (w_eff_state)
            BOOT: begin
                flush_d = 1'b1;
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            RUN: begin
                if (w_mem_stall) begin
                    {stall_f, stall_d, stall_e, stall_m} = '1;
                    w_state_nxt = MEM_WAIT;
                    w_saved_nxt = RUN;
                end else if (pc_src_e) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    if (REDIRECT_BUBBLES > 0) begin
                        w_state_nxt = REDIRECT;
                        w_cnt_nxt   = REDIR_CNT;
                    end
                end else if (w_load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            REDIRECT: begin
                if (w_mem_stall) begin
                    {stall_f, stall_d, stall_e, stall_m} = '1;
                    w_state_nxt = MEM_WAIT;
                    w_saved_nxt = REDIRECT;
                end else begin
                    flush_d = 1'b1;
                    if (r_cnt <= CNT_ONE) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                    end
                end
            end
            MEM_WAIT: begin
                {stall_f, stall_d, stall_e, stall_m} = '1;
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase

        if (!rst_n) begin
            {stall_f, stall_d, stall_e, stall_m} = '0;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // State, bubble counter and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= RST_STATE;
            r_saved        <= RUN;
            r_cnt          <= BOOT_CNT;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_saved <= w_saved_nxt;
            r_cnt   <= w_cnt_nxt;
            if (stall_f && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + PERF_ONE;
            end
        end
    end

endmodule
